fifo_uart_tx: RTL and testbench



---
 rtl/fifo_uart_tx.sv | 114 +++++++++++
 tb/tb_fifo_uart_tx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// Drains a first-word-fall-through FIFO and serializes each word as WIDTH/8
// back-to-back 8N1 UART frames, least significant byte first.
module fifo_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_rget,
  input  logic             hold,
  output logic             tx,
  output logic             busy
);

  localparam int BYTES = WIDTH / 8;
  localparam int TW    = $clog2(CLKS_PER_BIT);
  localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [2:0]       bit_q, bit_d;
  logic [BW-1:0]    byte_q, byte_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             pop_ok, tick_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    // rst gates the pop so a word is never consumed while reset is held
    pop_ok    = !fifo_empty && !hold && !rst;
    tick_last = (timer_q == LAST_TICK);
    state_d   = state_q;
    timer_d   = tick_last ? '0 : timer_q + 1'b1;
    bit_d     = bit_q;
    byte_d    = byte_q;
    shift_d   = shift_q;
    fifo_rget = 1'b0;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (pop_ok) begin
          fifo_rget = 1'b1;
          shift_d   = fifo_dout;
          byte_d    = '0;
          state_d   = START;
        end
      end
      START: begin
        if (tick_last) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick_last) begin
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 1'b1;
        end
      end
      STOP: begin
        if (tick_last) begin
          // after 8 shifts per byte the next byte already sits in shift[7:0]
          if (byte_q != LAST_BYTE) begin
            byte_d  = byte_q + 1'b1;
            state_d = START;
          end else if (pop_ok) begin
            fifo_rget = 1'b1;
            shift_d   = fifo_dout;
            byte_d    = '0;
            state_d   = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
    endcase

    // line level follows the next state so tx falls on the popping edge
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign tx   = tx_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: 8-bit and 16-bit instances fed from queue FIFO
// models, with a UART receiver checking decoded bytes against a scoreboard.
module tb_fifo_uart_tx;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  dout8  = '0;
  logic        empty8 = 1'b1;
  logic        rget8, tx8, busy8;
  logic        hold8  = 1'b0;
  logic [15:0] dout16 = '0;
  logic        empty16 = 1'b1;
  logic        rget16, tx16, busy16;
  logic        hold16 = 1'b0;

  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB)) u_dut8 (
    .clk(clk), .rst(rst), .fifo_dout(dout8), .fifo_empty(empty8),
    .fifo_rget(rget8), .hold(hold8), .tx(tx8), .busy(busy8));

  fifo_uart_tx #(.WIDTH(16), .CLKS_PER_BIT(CPB)) u_dut16 (
    .clk(clk), .rst(rst), .fifo_dout(dout16), .fifo_empty(empty16),
    .fifo_rget(rget16), .hold(hold16), .tx(tx16), .busy(busy16));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // FIFO models and scoreboards
  logic [7:0]  q8[$];
  logic [15:0] q16[$];
  logic [7:0]  exp8[$];
  logic [7:0]  exp16[$];
  logic        pend8 = 1'b0, pend16 = 1'b0;
  int          pops8 = 0, pops16 = 0;
  int          cyc = 0;

  task automatic push8(input logic [7:0] w);
    q8.push_back(w);
    exp8.push_back(w);
  endtask

  task automatic push16(input logic [15:0] w);
    q16.push_back(w);
    exp16.push_back(w[7:0]);
    exp16.push_back(w[15:8]);
  endtask

  always @(posedge clk) begin
    cyc++;
    #1;
    if (pend8 && !rst) begin
      q8.delete(0);
      pops8++;
    end
    if (pend16 && !rst) begin
      q16.delete(0);
      pops16++;
    end
    dout8   = (q8.size() != 0) ? q8[0] : '0;
    empty8  = (q8.size() == 0);
    dout16  = (q16.size() != 0) ? q16[0] : '0;
    empty16 = (q16.size() == 0);
  end

  // UART receivers and activity monitors
  int         rx_act[2], rx_cnt[2], frames[2], busy_cnt[2];
  int         last_start[2], prev_start[2];
  logic [7:0] rx_sh[2];
  int         rget_last8 = 0, rget_prev8 = 0;

  task automatic rx_step(input int d, input logic txv);
    int c;
    logic [31:0] e;
    if (rx_act[d] == 0) begin
      if (txv == 1'b0) begin
        rx_act[d]     = 1;
        rx_cnt[d]     = 1;
        prev_start[d] = last_start[d];
        last_start[d] = cyc;
      end
    end else begin
      c = rx_cnt[d];
      if (c == CPB / 2) check("start_bit", {31'b0, txv}, 32'd0);
      if (c >= CPB && c < 9 * CPB && (c % CPB) == CPB / 2)
        rx_sh[d] = {txv, rx_sh[d][7:1]};
      if (c == 9 * CPB + CPB / 2) begin
        check("stop_bit", {31'b0, txv}, 32'd1);
        if (d == 0) e = (exp8.size() != 0)  ? {24'b0, exp8.pop_front()}  : 32'h100;
        else        e = (exp16.size() != 0) ? {24'b0, exp16.pop_front()} : 32'h100;
        check(d == 0 ? "rx8_byte" : "rx16_byte", {24'b0, rx_sh[d]}, e);
        frames[d]++;
      end
      if (c == 10 * CPB - 1) rx_act[d] = 0;
      rx_cnt[d] = c + 1;
    end
  endtask

  always @(negedge clk) begin
    pend8  = rget8;
    pend16 = rget16;
    check("rget8_when_empty", {31'b0, rget8 & empty8}, 32'd0);
    check("rget16_when_empty", {31'b0, rget16 & empty16}, 32'd0);
    if (rget8) begin
      rget_prev8 = rget_last8;
      rget_last8 = cyc;
    end
    if (busy8)  busy_cnt[0]++;
    if (busy16) busy_cnt[1]++;
    if (rst) begin
      rx_act[0] = 0;
      rx_act[1] = 0;
    end else begin
      rx_step(0, tx8);
      rx_step(1, tx16);
    end
  end

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    int stable = 0;
    while (n < max_cyc && stable < 3) begin
      @(negedge clk);
      if (!busy8 && !busy16 && empty8 && empty16 && rx_act[0] == 0 && rx_act[1] == 0)
        stable++;
      else
        stable = 0;
      n++;
    end
    check("wait_idle_timeout", {31'b0, stable >= 3}, 32'd1);
  endtask

  task automatic wait_busy8(input int max_cyc);
    int n = 0;
    while (n < max_cyc && !busy8) begin
      @(negedge clk);
      n++;
    end
    check("wait_busy8_timeout", {31'b0, busy8}, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int b8, b16, f8;
    logic viol;
    for (int i = 0; i < 2; i++) begin
      rx_act[i] = 0; rx_cnt[i] = 0; frames[i] = 0; busy_cnt[i] = 0;
      last_start[i] = 0; prev_start[i] = 0; rx_sh[i] = '0;
    end

    // reset held with data waiting
    push8(8'hA5);
    push16(16'h1234);
    repeat (3) @(posedge clk);
    #2;
    check("rst_tx8", {31'b0, tx8}, 32'd1);
    check("rst_busy8", {31'b0, busy8}, 32'd0);
    check("rst_rget8", {31'b0, rget8}, 32'd0);
    check("rst_tx16", {31'b0, tx16}, 32'd1);
    check("rst_rget16", {31'b0, rget16}, 32'd0);
    check("rst_no_pop", pops8 + pops16, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // single byte 0xA5 and multi-byte 0x1234
    b8 = busy_cnt[0];
    b16 = busy_cnt[1];
    wait_idle(300);
    check("single_pops", pops8, 32'd1);
    check("single_busy", busy_cnt[0] - b8, 32'd40);
    check("single_frames", frames[0], 32'd1);
    check("multi_pops", pops16, 32'd1);
    check("multi_busy", busy_cnt[1] - b16, 32'd80);
    check("multi_frames", frames[1], 32'd2);
    check("multi_gap", last_start[1] - prev_start[1], 32'd40);

    // back-to-back 0x01, 0x80
    b8 = busy_cnt[0];
    push8(8'h01);
    push8(8'h80);
    wait_idle(300);
    check("b2b_pops", pops8, 32'd3);
    check("b2b_busy", busy_cnt[0] - b8, 32'd80);
    check("b2b_rget_spacing", rget_last8 - rget_prev8, 32'd40);
    check("b2b_start_spacing", last_start[0] - prev_start[0], 32'd40);

    // hold asserted during DATA of the first of two words
    f8 = frames[0];
    push8(8'h5A);
    push8(8'hC3);
    wait_busy8(20);
    repeat (12) @(posedge clk);
    #1 hold8 = 1'b1;
    while (busy8) @(negedge clk);
    viol = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (rget8 || !tx8) viol = 1'b1;
    end
    check("hold_quiet", {31'b0, viol}, 32'd0);
    check("hold_pops", pops8, 32'd4);
    check("hold_first_frame", frames[0] - f8, 32'd1);
    @(posedge clk);
    #1 hold8 = 1'b0;
    @(negedge clk);
    check("hold_release_rget", {31'b0, rget8}, 32'd1);
    @(negedge clk);
    check("hold_release_start", {31'b0, tx8}, 32'd0);
    wait_idle(200);
    check("hold_final_pops", pops8, 32'd5);

    // reset during DATA of 0xFF with 0x3C queued behind it
    push8(8'hFF);
    wait_busy8(20);
    push8(8'h3C);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_tx8", {31'b0, tx8}, 32'd1);
    check("midrst_busy8", {31'b0, busy8}, 32'd0);
    check("midrst_rget8", {31'b0, rget8}, 32'd0);
    void'(exp8.pop_front());
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_idle(200);
    check("midrst_pops", pops8, 32'd7);
    check("exp8_drained", exp8.size(), 32'd0);
    check("exp16_drained", exp16.size(), 32'd0);
    check("multi_no_second_pop", pops16, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
